// File: rtl/line_matrix_ctrl_if.sv
// Pixel stream in, 3-row column stream out, between the line-matrix sequencer and its
// neighbours. The master is the pixel source / column sink; the slave is the sequencer.
interface line_matrix_ctrl_if #(
  parameter int unsigned DW = 11
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [DW-1:0] out_row0;
  logic [DW-1:0] out_row1;
  logic [DW-1:0] out_row2;
  logic          out_eol;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_row0, out_row1, out_row2, out_eol
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_row0, out_row1, out_row2, out_eol
  );
endinterface

// File: rtl/line_matrix_ctrl.sv
// Sequencer for two external line FIFOs (A = row N-1, B = row N-2) that builds a 3-pixel
// vertical column per input pixel once two rows of the frame are buffered.
module line_matrix_ctrl #(
  parameter int unsigned DW      = 11,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned RST_CYC = 6,
  parameter int unsigned MAX_W   = 2047
) (
  input  logic                        clk,
  input  logic                        srst,
  input  logic                        frame_start,
  input  logic [$clog2(MAX_W+1)-1:0]  cfg_width,
  line_matrix_ctrl_if.slave           pix,
  output logic                        fa_wr_en,
  output logic                        fa_rd_en,
  output logic                        fb_wr_en,
  output logic                        fb_rd_en,
  output logic [DW-1:0]               fa_din,
  output logic [DW-1:0]               fb_din,
  input  logic [DW-1:0]               fa_dout,
  input  logic [DW-1:0]               fb_dout,
  input  logic                        fa_full,
  input  logic                        fa_empty,
  input  logic                        fb_full,
  input  logic                        fb_empty,
  output logic                        fifo_srst,
  output logic                        err
);

  localparam int unsigned WW = $clog2(MAX_W + 1);
  localparam int unsigned CW = $clog2(RST_CYC + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFrst  = 3'd1;
  localparam logic [2:0] StFill0 = 3'd2;
  localparam logic [2:0] StFill1 = 3'd3;
  localparam logic [2:0] StRun   = 3'd4;

  typedef struct packed {
    logic          vld;
    logic          eol;
    logic [2:0]    tag;
    logic [DW-1:0] data;
  } stage_t;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] rst_cnt_q, rst_cnt_d;
  logic [WW-1:0] width_q;
  logic [WW-1:0] col_q, col_d;

  stage_t [RD_LAT-1:0] pipe_q, pipe_d;
  stage_t              dly;

  logic          out_valid_q;
  logic          out_eol_q;
  logic [DW-1:0] out_row0_q, out_row1_q, out_row2_q;
  logic          err_q;

  logic running, issue, line_end, dly_run, err_set;

  assign running  = state_q inside {StFill0, StFill1, StRun};
  // A pixel presented together with frame_start belongs to the aborted frame: drop it.
  assign issue    = pix.in_valid && running && !frame_start;
  assign line_end = (col_q == width_q - WW'(1));

  // Issue stage: request the matching older-row pixels from both FIFOs.
  assign fa_rd_en = issue && (state_q == StFill1 || state_q == StRun);
  assign fb_rd_en = issue && (state_q == StRun);

  // Align stage: FIFO data for this pixel is now valid at fa_dout / fb_dout.
  assign dly      = pipe_q[RD_LAT-1];
  assign dly_run  = dly.vld && (dly.tag == StRun);
  assign fa_wr_en = dly.vld;
  assign fa_din   = fa_wr_en ? dly.data : '0;
  assign fb_wr_en = dly.vld && (dly.tag == StFill1 || dly.tag == StRun);
  // Row N-1 leaving FIFO A becomes row N-2 in FIFO B.
  assign fb_din   = fb_wr_en ? fa_dout : '0;

  assign fifo_srst = (state_q == StFrst);
  assign err_set   = (fa_wr_en && fa_full) || (fa_rd_en && fa_empty) ||
                     (fb_wr_en && fb_full) || (fb_rd_en && fb_empty);

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    col_d     = col_q;
    case (state_q)
      StFrst: begin
        if (rst_cnt_q == CW'(RST_CYC - 1)) state_d = StFill0;
        else                               rst_cnt_d = rst_cnt_q + CW'(1);
      end
      StFill0: if (issue && line_end) state_d = StFill1;
      StFill1: if (issue && line_end) state_d = StRun;
      default: ;
    endcase
    if (issue) col_d = line_end ? '0 : col_q + WW'(1);
    if (frame_start) begin
      state_d   = StFrst;
      rst_cnt_d = '0;
      col_d     = '0;
    end
  end

  always_comb begin
    pipe_d      = pipe_q << $bits(stage_t);
    pipe_d[0]   = '{vld: issue, eol: line_end, tag: state_q, data: pix.in_data};
    if (frame_start) pipe_d = '0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= StIdle;
      rst_cnt_q   <= '0;
      width_q     <= '0;
      col_q       <= '0;
      pipe_q      <= '0;
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_row0_q  <= '0;
      out_row1_q  <= '0;
      out_row2_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      col_q     <= col_d;
      pipe_q    <= pipe_d;
      if (frame_start) width_q <= cfg_width;

      // Output stage: only rows 2.. of a frame produce columns; data holds otherwise.
      out_valid_q <= dly_run && !frame_start;
      if (dly_run) begin
        out_row2_q <= dly.data;
        out_row1_q <= fa_dout;
        out_row0_q <= fb_dout;
        out_eol_q  <= dly.eol;
      end

      if (frame_start) err_q <= 1'b0;
      else             err_q <= err_q | err_set;
    end
  end

  assign pix.in_ready  = running;
  assign pix.out_valid = out_valid_q;
  assign pix.out_row0  = out_row0_q;
  assign pix.out_row1  = out_row1_q;
  assign pix.out_row2  = out_row2_q;
  assign pix.out_eol   = out_eol_q;
  assign err           = err_q;

endmodule
